// File: rtl/mdu_defs.sv
// Shared MDU definitions: op codes, FSM states, default latencies, HI/LO payload.
// Optional MADD family is enabled with the MDU_MADD_EN macro.
package mdu_defs;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned OP_W         = 4;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Multiply-class ops (MULT latency); the MADD family only counts when enabled.
  function automatic logic is_mult(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (MADD_EN && (op >= OP_MADD) && (op <= OP_MSUBU));
  endfunction

  // Ops that occupy the unit for a busy countdown.
  function automatic logic is_long(input logic [OP_W-1:0] op);
    return is_mult(op) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit MDU result, including divide-by-zero and overflow rules.
// The MADD family datapath exists only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
`ifdef MDU_MADD_EN
  input  hilo_t           acc,
`endif
  output hilo_t           res_c
);

  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic            signed_div;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;

  // Products, magnitude divide, and result selection by op.
  always_comb begin
    prod_s     = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
    prod_u     = {32'd0, d1} * {32'd0, d2};
    signed_div = (op == OP_DIV);
    abs_a      = (signed_div && d1[31]) ? (~d1 + 32'd1) : d1;
    abs_b      = (signed_div && d2[31]) ? (~d2 + 32'd1) : d2;
    q_mag      = (abs_b == '0) ? '0 : abs_a / abs_b;
    r_mag      = (abs_b == '0) ? '0 : abs_a % abs_b;
    res_c      = '0;
    case (op)
      OP_MULT:  res_c = hilo_t'(prod_s);
      OP_MULTU: res_c = hilo_t'(prod_u);
      OP_DIV, OP_DIVU: begin
        if (d2 == '0) begin
          res_c.hi = d1;
          res_c.lo = '1;
        end else begin
          // 8000_0000 / -1 falls out naturally: magnitude 8000_0000 negates to itself.
          res_c.lo = (signed_div && (d1[31] ^ d2[31])) ? (~q_mag + 32'd1) : q_mag;
          res_c.hi = (signed_div && d1[31]) ? (~r_mag + 32'd1) : r_mag;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res_c = hilo_t'(64'(acc) + prod_s);
      OP_MADDU: res_c = hilo_t'(64'(acc) + prod_u);
      OP_MSUB:  res_c = hilo_t'(64'(acc) - prod_s);
      OP_MSUBU: res_c = hilo_t'(64'(acc) - prod_u);
`endif
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: accepts one op, counts down a fixed
// latency, then commits HI/LO with a one-cycle done pulse.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (accumulate into {hi,lo}).
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic            cancel,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hilo_t            pend_q, pend_d;
  hilo_t            hilo_q, hilo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  hilo_t            arith_res;
  logic             accept_c;

  mdu_arith u_arith (
    .op    (op),
    .d1    (d1),
    .d2    (d2),
`ifdef MDU_MADD_EN
    .acc   (hilo_q),
`endif
    .res_c (arith_res)
  );

  // A start is taken only when idle and not flushed by the exception path.
  assign accept_c = start && !cancel && (state_q == ST_IDLE);

  // Next-state, countdown, pending result and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hilo_d  = hilo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (is_long(op)) begin
            pend_d  = arith_res;
            cnt_d   = is_mult(op) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else if (op == OP_MTHI) begin
            hilo_d.hi = d1;
          end else if (op == OP_MTLO) begin
            hilo_d.lo = d1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hilo_d  = pend_q;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hilo_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hilo_q  <= hilo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Stall is early: it covers the issue cycle before busy registers.
  assign stall_req = busy_q | (start & is_long(op) & ~cancel);
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hilo_q.hi;
  assign lo        = hilo_q.lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with an expected-result scoreboard.
module tb_mdu_ctrl;

  localparam logic [3:0] C_NOP   = 4'd0;
  localparam logic [3:0] C_MULT  = 4'd1;
  localparam logic [3:0] C_MULTU = 4'd2;
  localparam logic [3:0] C_DIV   = 4'd3;
  localparam logic [3:0] C_DIVU  = 4'd4;
  localparam logic [3:0] C_MTHI  = 4'd5;
  localparam logic [3:0] C_MTLO  = 4'd6;
  localparam logic [3:0] C_MADD  = 4'd7;
  localparam logic [3:0] C_MADDU = 4'd8;
  localparam logic [3:0] C_MSUB  = 4'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic        cancel;
  logic [31:0] d1, d2;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_hilo = '0;
  logic [63:0] sb_q[$];

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .cancel    (cancel),
    .d1        (d1),
    .d2        (d2),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result, written from the architectural definition.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    ps = longint'(sa) * longint'(sb);
    pu = 64'(a) * 64'(b);
    case (o)
      C_MULT:  return 64'(ps);
      C_MULTU: return pu;
      C_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      C_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      C_MADD:  return acc + 64'(ps);
      C_MADDU: return acc + pu;
      C_MSUB:  return acc - 64'(ps);
      default: return acc;
    endcase
  endfunction

  // Drive a start (held until the next edge) and record the expected commit.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    start = 1'b1;
    op    = o;
    d1    = a;
    d2    = b;
    if (push) sb_q.push_back(model(o, a, b, exp_hilo));
    #1;
    chk("stall_at_issue", 64'(stall_req), 64'd1);
  endtask

  // Wait (bounded) for done, counting busy cycles, then score the commit.
  task automatic wait_done(input int lat, input string tag);
    int          busy_cnt = 0;
    bit          seen = 1'b0;
    logic [63:0] expv;
    for (int i = 0; i < lat + 8 && !seen; i++) begin
      tick();
      start = 1'b0;
      op    = C_NOP;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      expv = sb_q.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, expv);
      exp_hilo = expv;
    end
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // MTHI/MTLO: single-cycle write, no busy or done.
  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    start = 1'b1;
    op    = o;
    d1    = v;
    #1;
    chk("mt_stall", 64'(stall_req), 64'd0);
    tick();
    start = 1'b0;
    op    = C_NOP;
    if (o == C_MTHI) exp_hilo[63:32] = v;
    else exp_hilo[31:0] = v;
    chk("mt_hilo", {hi, lo}, exp_hilo);
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
  endtask

  initial begin
    int done_seen;
    reset  = 1'b1;
    start  = 1'b0;
    op     = C_NOP;
    cancel = 1'b0;
    d1     = '0;
    d2     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);

    // Arithmetic and boundary cases.
    issue(C_MULT, 32'd3, 32'hFFFF_FFFE, 1'b1);   wait_done(5, "mult");
    chk("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    issue(C_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);  wait_done(5, "multu");
    chk("multu_const", {hi, lo}, {32'd1, 32'hFFFF_FFFE});
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);    wait_done(10, "div");
    chk("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(C_DIVU, 32'd7, 32'd0, 1'b1);           wait_done(10, "divu0");
    chk("divu0_const", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_done(10, "div_ovf");
    chk("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    issue(C_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);  wait_done(10, "div_negb");
    issue(C_DIVU, 32'hF000_0000, 32'd7, 1'b1);   wait_done(10, "divu");
    issue(C_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done(5, "mult_min");

    // start with cancel in the same cycle: nothing accepted.
    start  = 1'b1;
    op     = C_DIV;
    d1     = 32'd50;
    d2     = 32'd3;
    cancel = 1'b1;
    #1;
    chk("cancel_stall", 64'(stall_req), 64'd0);
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    op     = C_NOP;
    chk("cancel_busy", 64'(busy), 64'd0);
    tick();
    chk("cancel_busy2", 64'(busy), 64'd0);
    chk("cancel_hilo", {hi, lo}, exp_hilo);

    // Second start during RUN is ignored; cancel during RUN has no effect.
    issue(C_MULT, 32'd1234, 32'd5678, 1'b1);
    tick();
    start = 1'b0;
    tick();
    start  = 1'b1;
    op     = C_MULT;
    d1     = 32'd9;
    d2     = 32'd9;
    cancel = 1'b1;
    #1;
    chk("run_stall", 64'(stall_req), 64'd1);
    wait_done(3, "ignored_start");
    cancel = 1'b0;

    // Reset at busy cycle 3 of a DIV aborts with no commit.
    issue(C_DIV, 32'd1000, 32'd3, 1'b0);
    tick();
    start = 1'b0;
    op    = C_NOP;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hilo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_hilo_held", {hi, lo}, 64'd0);

    // Move-to and unknown ops.
    mt(C_MTLO, 32'h1234_5678);
    mt(C_MTHI, 32'hCAFE_0001);
    start = 1'b1;
    op    = 4'd15;
    d1    = 32'hDEAD_BEEF;
    #1;
    chk("unk_stall", 64'(stall_req), 64'd0);
    tick();
    start = 1'b0;
    chk("unk_busy", 64'(busy), 64'd0);
    chk("unk_hilo", {hi, lo}, exp_hilo);

`ifdef MDU_MADD_EN
    mt(C_MTHI, 32'd0);
    mt(C_MTLO, 32'hFFFF_FFFF);
    issue(C_MADDU, 32'd1, 32'd1, 1'b1);           wait_done(5, "maddu");
    chk("maddu_const", {hi, lo}, {32'd1, 32'd0});
    issue(C_MSUB, 32'd2, 32'hFFFF_FFFD, 1'b1);    wait_done(5, "msub");
    issue(C_MADD, 32'hFFFF_FFFF, 32'd5, 1'b1);    wait_done(5, "madd");
`else
    start = 1'b1;
    op    = C_MADDU;
    d1    = 32'd1;
    d2    = 32'd1;
    #1;
    chk("madd_off_stall", 64'(stall_req), 64'd0);
    tick();
    start = 1'b0;
    op    = C_NOP;
    chk("madd_off_busy", 64'(busy), 64'd0);
    tick();
    chk("madd_off_hilo", {hi, lo}, exp_hilo);
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer and scheduler for the EX-stage multiply/divide resource.
- Accepts one MDU operation per start, runs a fixed-latency busy countdown, and commits HI/LO on completion.
- Drives the stall request that the stall controller uses to hold mult/div/mfhi/mflo/mthi/mtlo in D.
- Cancel input lets the exception path suppress an operation issued in the faulting cycle.

Parameters:
- MULT_LAT, 5, cycles busy for MULT/MULTU (and MADD family), must be >= 1
- DIV_LAT, 10, cycles busy for DIV/DIVU, must be >= 1
- CNT_W, 4, countdown width, must hold max(MULT_LAT, DIV_LAT)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  issue qualifier; op valid this cycle
- op  in  4  operation code (mdu_defs encoding)
- cancel  in  1  exception flush of EX; suppresses a start this cycle
- d1  in  32  rs operand (forwarded)
- d2  in  32  rt operand (forwarded)
- busy  out  1  long operation in flight
- stall_req  out  1  busy | (start & op is long & ~cancel)
- done  out  1  one-cycle pulse in the cycle HI/LO show the new result
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Reset mid-operation aborts it with no commit.
- States: IDLE, RUN.
- IDLE + accepted long op (MULT/MULTU/DIV/DIVU, or MADD family when enabled):
  - latch the result computed from d1/d2 into pending {ph,pl};
  - load counter with MULT_LAT or DIV_LAT;
  - go to RUN.
- RUN: counter decrements each cycle. At count==1 the next edge commits {ph,pl} to {hi,lo}, returns to IDLE, and sets done for one cycle.
- Timing: start in cycle T → busy high T+1..T+LAT; new hi/lo and done=1 in T+LAT+1; busy=0 in T+LAT+1.
- MTHI/MTLO: accepted only in IDLE; write d1 to hi or lo at the next edge. No busy, no done.
- Any start while RUN (or while MTHI/MTLO would race a pending commit) is ignored. The stall controller guarantees this does not occur.
- start & cancel in the same cycle: nothing accepted, no state change.
- cancel during RUN has no effect; an in-flight operation always completes.
- Unknown or NOP op codes: ignored.
- Arithmetic:
  - MULT: signed 32x32→64.
  - MULTU: unsigned 32x32→64.
  - In both, HI = [63:32], LO = [31:0].
  - DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
- Divide boundaries (decided, deterministic):
  - divisor 0 → LO=32'hFFFF_FFFF, HI=d1;
  - signed 32'h8000_0000 / -1 → LO=32'h8000_0000, HI=0.
- stall_req is combinational from start/op/cancel plus registered busy. hi/lo are purely registered.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - Operation is {hi,lo} ± product (signed or unsigned), mod 2^64.
  - {hi,lo} is sampled at accept.
  - Latency MULT_LAT, same completion rules as MULT.
- Undefined: these codes are treated as NOP. Counter and pending logic are unchanged.

Decomposition:
- Shared header/package mdu_defs holds:
  - op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - state encodings;
  - default latencies.
- mdu_defs is also included by EController and StallController.
- One natural sub-module, mdu_arith: combinational 64-bit result from op, d1, d2, {hi,lo}, including the divide-boundary rules.

Test Plan:
- MULT d1=3, d2=32'hFFFF_FFFE at T → busy T+1..T+5; T+6: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done=1.
- MULTU d1=32'hFFFF_FFFF, d2=2 → hi=1, lo=32'hFFFF_FFFE after 5 busy cycles.
- DIV d1=-7, d2=2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF after 10 busy cycles. DIVU d1=7, d2=0 → lo=32'hFFFF_FFFF, hi=7.
- start DIV with cancel=1 → busy stays 0, hi/lo unchanged. Second MULT start during RUN → ignored; first result commits unchanged.
- reset asserted at busy cycle 3 of DIV → next cycle busy=0, hi=lo=0, no done pulse.
- MTLO d1=32'h1234_5678 in IDLE → lo=32'h1234_5678 next cycle, busy stays 0. With MDU_MADD_EN: hi=0, lo=32'hFFFF_FFFF, MADDU 1,1 → hi=1, lo=0.
